adder_issue_scheduler: RTL and testbench

//  Issue/writeback controller for the shared 16-bit add/sub unit in the Tomasulo core.

---
 rtl/adder_issue_scheduler.sv | 157 +++++++++++++++
 tb/tb_adder_issue_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_issue_scheduler.sv
// rtl/adder_issue_scheduler.sv - round-robin issue and CDB writeback control for the shared add/sub unit
// Optional ADDER_OVF_FLAG_EN adds cdb_ovf, a signed-overflow flag registered with cdb_data.
module adder_issue_scheduler #(
  parameter int NUM_RS  = 3,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int LATENCY = 2
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic [NUM_RS-1:0]        rs_ready,
  input  logic [NUM_RS-1:0]        rs_op,
  input  logic [NUM_RS*DATA_W-1:0] rs_vj,
  input  logic [NUM_RS*DATA_W-1:0] rs_vk,
  input  logic [NUM_RS*TAG_W-1:0]  rs_tag,
  output logic [NUM_RS-1:0]        rs_issue,
  output logic                     cdb_req,
  input  logic                     cdb_gnt,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic                     busy
`ifdef ADDER_OVF_FLAG_EN
  ,
  output logic                     cdb_ovf
`endif
);

  localparam int PTR_W = $clog2(NUM_RS);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic [DATA_W-1:0]  vj_q, vk_q;
  logic [TAG_W-1:0]   tag_q;

  logic               issue_slot, issue_fire, pick_valid;
  logic [PTR_W-1:0]   pick_idx, scan_ptr;
  logic [PTR_W:0]     scan_sum;
  logic               sel_op;
  logic [DATA_W-1:0]  sel_vj, sel_vk, exec_res;
  logic [TAG_W-1:0]   sel_tag;

  // Descending scan so the entry closest to rr_ptr overwrites the others and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_ptr   = '0;
    for (int k = NUM_RS - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_RS))
        scan_sum = scan_sum - (PTR_W+1)'(NUM_RS);
      scan_ptr = scan_sum[PTR_W-1:0];
      if (rs_ready[scan_ptr]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_ptr;
      end
    end
  end

  always_comb begin
    sel_op  = 1'b0;
    sel_vj  = '0;
    sel_vk  = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        sel_op  = rs_op[i];
        sel_vj  = rs_vj[i*DATA_W +: DATA_W];
        sel_vk  = rs_vk[i*DATA_W +: DATA_W];
        sel_tag = rs_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign issue_slot = (state == IDLE) || ((state == WB) && cdb_gnt);
  assign issue_fire = Resetn && issue_slot && pick_valid;
  assign exec_res   = op_q ? (vj_q - vk_q) : (vj_q + vk_q);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_fire) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = WB;
      WB:      if (cdb_gnt) state_nxt = issue_fire ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rs_issue = '0;
    if (issue_fire)
      rs_issue[pick_idx] = 1'b1;
    busy = (state != IDLE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rr_ptr <= '0;
      cnt    <= '0;
      op_q   <= 1'b0;
      vj_q   <= '0;
      vk_q   <= '0;
      tag_q  <= '0;
    end else if (issue_fire) begin
      rr_ptr <= (pick_idx == PTR_W'(NUM_RS - 1)) ? '0 : pick_idx + 1'b1;
      cnt    <= CNT_W'(LATENCY - 1);
      op_q   <= sel_op;
      vj_q   <= sel_vj;
      vk_q   <= sel_vk;
      tag_q  <= sel_tag;
    end else if ((state == EXEC) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Result registers hold through backpressure; only the request drops on grant.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cdb_req  <= 1'b0;
      cdb_tag  <= '0;
      cdb_data <= '0;
    end else if ((state == EXEC) && (cnt == '0)) begin
      cdb_req  <= 1'b1;
      cdb_tag  <= tag_q;
      cdb_data <= exec_res;
    end else if ((state == WB) && cdb_gnt) begin
      cdb_req  <= 1'b0;
    end
  end

`ifdef ADDER_OVF_FLAG_EN
  logic ovf_res;
  assign ovf_res = op_q
    ? ((vj_q[DATA_W-1] != vk_q[DATA_W-1]) && (exec_res[DATA_W-1] != vj_q[DATA_W-1]))
    : ((vj_q[DATA_W-1] == vk_q[DATA_W-1]) && (exec_res[DATA_W-1] != vj_q[DATA_W-1]));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      cdb_ovf <= 1'b0;
    else if ((state == EXEC) && (cnt == '0))
      cdb_ovf <= ovf_res;
  end
`endif

endmodule

// File: tb/tb_adder_issue_scheduler.sv
// tb/tb_adder_issue_scheduler.sv - directed and random checks of adder_issue_scheduler against a timing/arithmetic model
module tb_adder_issue_scheduler;
  localparam int NUM_RS  = 3;
  localparam int DATA_W  = 16;
  localparam int TAG_W   = 3;
  localparam int LATENCY = 2;

  logic                     Clock = 1'b0;
  logic                     Resetn = 1'b0;
  logic [NUM_RS-1:0]        rs_ready = '0;
  logic [NUM_RS-1:0]        rs_op = '0;
  logic [NUM_RS*DATA_W-1:0] rs_vj = '0;
  logic [NUM_RS*DATA_W-1:0] rs_vk = '0;
  logic [NUM_RS*TAG_W-1:0]  rs_tag = '0;
  logic [NUM_RS-1:0]        rs_issue;
  logic                     cdb_req;
  logic                     cdb_gnt = 1'b0;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic                     busy;
`ifdef ADDER_OVF_FLAG_EN
  logic                     cdb_ovf;
`endif

  adder_issue_scheduler #(
    .NUM_RS(NUM_RS), .DATA_W(DATA_W), .TAG_W(TAG_W), .LATENCY(LATENCY)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .rs_ready(rs_ready), .rs_op(rs_op),
    .rs_vj(rs_vj), .rs_vk(rs_vk), .rs_tag(rs_tag), .rs_issue(rs_issue),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .busy(busy)
`ifdef ADDER_OVF_FLAG_EN
    , .cdb_ovf(cdb_ovf)
`endif
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one op in flight, result due at an absolute edge number.
  int              edge_no = 0;
  bit              m_inflight = 0;
  bit              m_req = 0;
  int              m_due = 0;
  int              m_rr = 0;
  logic [15:0]     m_data = '0;
  logic [2:0]      m_tag = '0;
  bit              m_ovf = 0;
  logic [2:0]      issue_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input bit op, input logic [15:0] vj,
                           input logic [15:0] vk, input logic [2:0] tag);
    rs_op[i] = op;
    rs_vj[i*DATA_W +: DATA_W] = vj;
    rs_vk[i*DATA_W +: DATA_W] = vk;
    rs_tag[i*TAG_W +: TAG_W] = tag;
  endtask

  // One clock: check at negedge, then advance past posedge and update model.
  task automatic cycle();
    bit           slot, granted;
    int           idx, j, sv, a, b;
    logic [2:0]   exp_issue;
    logic [15:0]  vj, vk, res;
    logic [2:0]   tg;
    bit           ovf;
    @(negedge Clock);
    granted   = m_req && cdb_gnt;
    slot      = !m_inflight || granted;
    idx       = -1;
    exp_issue = '0;
    if (slot) begin
      for (int k = 0; k < NUM_RS; k++) begin
        j = (m_rr + k) % NUM_RS;
        if (rs_ready[j] && idx < 0) idx = j;
      end
    end
    if (idx >= 0) exp_issue[idx] = 1'b1;
    check("rs_issue", 32'(rs_issue), 32'(exp_issue));
    check("cdb_req", 32'(cdb_req), 32'(m_req));
    check("busy", 32'(busy), 32'(m_inflight));
    if (m_req) begin
      check("cdb_data", 32'(cdb_data), 32'(m_data));
      check("cdb_tag", 32'(cdb_tag), 32'(m_tag));
`ifdef ADDER_OVF_FLAG_EN
      check("cdb_ovf", 32'(cdb_ovf), 32'(m_ovf));
`endif
    end
    if (rs_issue != '0) issue_log.push_back(rs_issue);
    res = '0; tg = '0; ovf = 0;
    if (idx >= 0) begin
      vj = rs_vj[idx*DATA_W +: DATA_W];
      vk = rs_vk[idx*DATA_W +: DATA_W];
      tg = rs_tag[idx*TAG_W +: TAG_W];
      a  = int'($signed(vj));
      b  = int'($signed(vk));
      sv = rs_op[idx] ? a - b : a + b;
      res = 16'(sv);
      ovf = (sv > 32767) || (sv < -32768);
    end
    @(posedge Clock);
    #1;
    edge_no++;
    if (granted) begin
      m_req = 0;
      m_inflight = 0;
    end
    if (idx >= 0) begin
      m_inflight = 1;
      m_due  = edge_no + LATENCY;
      m_data = res;
      m_tag  = tg;
      m_ovf  = ovf;
      m_rr   = (idx + 1) % NUM_RS;
    end else if (m_inflight && !m_req && edge_no == m_due) begin
      m_req = 1;
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    check("rst_issue", 32'(rs_issue), 32'd0);
    check("rst_req", 32'(cdb_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(cdb_data), 32'd0);
    check("rst_tag", 32'(cdb_tag), 32'd0);
    @(posedge Clock);
    #1;
    check("rst_hold_issue", 32'(rs_issue), 32'd0);
    rs_ready = '0;
    cdb_gnt  = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    m_inflight = 0; m_req = 0; m_rr = 0;
    @(posedge Clock);
    #1;
    edge_no++;
  endtask

  initial begin
    logic [15:0] hold_data;
    logic [2:0]  hold_tag;
    int          waited;

    // Reset held with every entry ready
    rs_ready = 3'b111;
    #2;
    do_reset();

    // Single add on entry1
    set_entry(1, 1'b0, 16'd5, 16'd7, 3'd2);
    rs_ready = 3'b010;
    cycle();
    rs_ready = '0;
    cycle();
    cycle();
    check("t2_req", 32'(cdb_req), 32'd1);
    check("t2_data", 32'(cdb_data), 32'd12);
    check("t2_tag", 32'(cdb_tag), 32'd2);
    cdb_gnt = 1'b1;
    cycle();
    cdb_gnt = 1'b0;
    check("t2_idle", 32'(busy), 32'd0);

    // Subtraction wrap and signed overflow
    set_entry(0, 1'b1, 16'h0003, 16'h0005, 3'd4);
    rs_ready = 3'b001;
    cycle();
    rs_ready = '0;
    repeat (2) cycle();
    check("t3_sub", 32'(cdb_data), 32'h0000FFFE);
`ifdef ADDER_OVF_FLAG_EN
    check("t3_sub_ovf", 32'(cdb_ovf), 32'd0);
`endif
    cdb_gnt = 1'b1;
    cycle();
    cdb_gnt = 1'b0;
    set_entry(0, 1'b0, 16'h7FFF, 16'h0001, 3'd5);
    rs_ready = 3'b001;
    cycle();
    rs_ready = '0;
    repeat (2) cycle();
    check("t3_add", 32'(cdb_data), 32'h00008000);
`ifdef ADDER_OVF_FLAG_EN
    check("t3_add_ovf", 32'(cdb_ovf), 32'd1);
`endif
    cdb_gnt = 1'b1;
    cycle();
    cdb_gnt = 1'b0;

    // Round-robin with grant tied high
    do_reset();
    for (int i = 0; i < NUM_RS; i++)
      set_entry(i, 1'b0, 16'(i * 100), 16'd1, 3'(i + 1));
    issue_log.delete();
    rs_ready = 3'b111;
    cdb_gnt  = 1'b1;
    repeat (4 * (LATENCY + 1) - 2) cycle();
    rs_ready = '0;
    cdb_gnt  = 1'b0;
    check("t4_count", 32'(issue_log.size()), 32'd4);
    if (issue_log.size() == 4) begin
      check("t4_ord0", 32'(issue_log[0]), 32'b001);
      check("t4_ord1", 32'(issue_log[1]), 32'b010);
      check("t4_ord2", 32'(issue_log[2]), 32'b100);
      check("t4_ord3", 32'(issue_log[3]), 32'b001);
    end
    cdb_gnt = 1'b1;
    repeat (LATENCY + 1) cycle();
    cdb_gnt = 1'b0;

    // Backpressure in WB
    set_entry(2, 1'b1, 16'h1234, 16'h0234, 3'd6);
    rs_ready = 3'b100;
    cycle();
    rs_ready = 3'b111;
    waited = 0;
    while (!cdb_req && waited < 10) begin
      cycle();
      waited++;
    end
    check("t5_req_rose", 32'(cdb_req), 32'd1);
    hold_data = cdb_data;
    hold_tag  = cdb_tag;
    check("t5_data", 32'(hold_data), 32'h00001000);
    repeat (5) begin
      cycle();
      check("t5_req_stable", 32'(cdb_req), 32'd1);
      check("t5_data_stable", 32'(cdb_data), 32'(hold_data));
      check("t5_tag_stable", 32'(cdb_tag), 32'(hold_tag));
    end
    rs_ready = '0;
    cdb_gnt  = 1'b1;
    cycle();
    cdb_gnt  = 1'b0;
    check("t5_req_drop", 32'(cdb_req), 32'd0);

    // Reset while executing
    do_reset();
    set_entry(1, 1'b0, 16'd9, 16'd9, 3'd3);
    rs_ready = 3'b010;
    cycle();
    rs_ready = '0;
    do_reset();
    repeat (LATENCY + 2) cycle();
    check("t6_no_req", 32'(cdb_req), 32'd0);
    rs_ready = 3'b111;
    #1;
    check("t6_rr_zero", 32'(rs_issue), 32'b001);
    cycle();
    rs_ready = '0;
    cdb_gnt  = 1'b1;
    repeat (LATENCY + 1) cycle();
    cdb_gnt  = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rs_ready = 3'($urandom);
      for (int i = 0; i < NUM_RS; i++) begin
        case ($urandom_range(0, 3))
          0:       set_entry(i, 1'($urandom), 16'h7FFF, 16'($urandom), 3'($urandom));
          1:       set_entry(i, 1'($urandom), 16'h8000, 16'($urandom), 3'($urandom));
          default: set_entry(i, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
        endcase
      end
      cdb_gnt = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
